address_arbiter_mux: RTL
========================

// Module: address_arbiter_mux
// PURPOSE
//  Parametrised, registered address selector for the shared memory port.
//  CHANNELS requesters (ch0 = PC fetch, ch1 = IR operand, more for DMA/debug) each
//  present an address with a req line. A fixed-priority or round-robin arbiter
//  grants one channel and holds that channel's address stable for ACC_CYCLES cycles.
//  It then pulses done to the winner. Replaces the combinational PC/IR select.
// PARAMETERS
//  WIDTH      5  address width in bits
//  CHANNELS   2  number of requesters, >=2
//  ACC_CYCLES 1  cycles addr_out is held per access, >=1
//  RR_MODE    0  0 = fixed priority (lowest index wins); 1 = round-robin
// PORTS
//  clk        in   1               clock; all logic on rising edge
//  rst        in   1               synchronous reset, active-high
//  req        in   CHANNELS        per-channel request; held high until done seen
//  addr_in    in   CHANNELS*WIDTH  packed addresses; ch i = addr_in[i*WIDTH +: WIDTH]
//  addr_out   out  WIDTH           registered granted address
//  addr_valid out  1               addr_out valid, access in progress
//  grant      out  CHANNELS        one-hot owner of current access; 0 when idle
//  done       out  CHANNELS        one-cycle pulse on owner in last access cycle
//  busy       out  1               high whenever state == ACCESS
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous and active-high.
//  Reset (rst=1 at a rising edge), including mid-access:
//   - state->IDLE; addr_out=0; addr_valid=0; grant=0; done=0; busy=0.
//   - count=0; RR pointer=0.
//   - The aborted access gets no done pulse.
//  FSM states: IDLE, ACCESS.
//  IDLE:
//   - If |req at edge t: pick winner w, latch addr_in[w], grant=onehot(w).
//   - Load count=ACC_CYCLES-1, go to ACCESS.
//   - Outputs are visible from t+1. Latency req->addr_valid = 1 cycle.
//  ACCESS:
//   - addr_valid=1; busy=1; addr_out and grant frozen.
//   - Changes on addr_in[w] are ignored while frozen.
//   - count decrements by 1 each cycle; cycle with count==0 is the last cycle.
//   - done[w]=1 only in the last cycle. ACC_CYCLES=1: done is in the first ACCESS cycle.
//  Last cycle, back-to-back:
//   - Arbitrate over req & ~grant; the owner is masked even if its req is still high.
//   - If a winner exists: next access starts on the next edge, no bubble, stays ACCESS.
//   - Otherwise: go to IDLE; addr_valid=0, grant=0 next cycle.
//   - addr_out holds its last value while IDLE.
//  Arbitration:
//   - RR_MODE=0: lowest set index wins.
//   - RR_MODE=1: search starts at ptr and wraps CHANNELS-1 -> 0.
//   - RR ptr := w+1 (mod CHANNELS), updated when w is granted.
//  Other rules:
//   - req dropped mid-access does not abort the access; it still completes with done.
//   - grant is always one-hot or zero; done is a subset of grant.
//   - count width = clog2(ACC_CYCLES)+1.
// TESTING
//  1 Reset: rst=1 two cycles, random req/addr
//    -> addr_out=0, addr_valid=0, grant=0, done=0, busy=0.
//  2 Latency, CHANNELS=2, ACC_CYCLES=3: req=01, ch0 addr=5'h0A at edge t
//    -> addr_out=0A and grant=01 at t+1..t+3; done=01 only at t+3; idle at t+4.
//  3 Priority, ACC_CYCLES=1, req=11 held continuously:
//    RR_MODE=0 -> grants 01,10,01,10 (masking);
//    RR_MODE=1 with CHANNELS=4, req=1111 -> grants 0001,0010,0100,1000,0001.
//  4 Freeze: ch1 granted with addr=5'h13, addr_in ch1 changes to 5'h1F mid-access
//    -> addr_out stays 13 until done.
//  5 Reset mid-access: rst=1 in 2nd of 3 ACCESS cycles
//    -> next cycle all outputs 0, no done; a new req is granted cleanly afterwards.
//  6 Back-to-back: ch0 done while ch1 req=1
//    -> grant=10 on the very next cycle, addr_valid never drops.

Source files
------------

// File: rtl/address_arbiter_mux.sv
// Registered address selector for the shared memory port: arbitrates CHANNELS requesters,
// holds the winner's address for ACC_CYCLES cycles and pulses done to the winner.
module address_arbiter_mux #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned ACC_CYCLES = 1,
    parameter int unsigned RR_MODE    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WIDTH-1:0]    addr_in,
    output logic [WIDTH-1:0]             addr_out,
    output logic                         addr_valid,
    output logic [CHANNELS-1:0]          grant,
    output logic [CHANNELS-1:0]          done,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(ACC_CYCLES) + 1;
    localparam int unsigned PW = $clog2(CHANNELS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       count;
    logic [PW-1:0]       ptr;
    logic [CHANNELS-1:0] cand;
    logic                found;
    logic [PW-1:0]       win;
    logic                last;
    int unsigned         idx;

    // Arbitration runs in IDLE and in the last ACCESS cycle; the current owner is masked.
    always_comb begin
        last  = (state == ACCESS) && (count == '0);
        cand  = '0;
        if (state == IDLE)
            cand = req;
        else if (last)
            cand = req & ~grant;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            idx = (RR_MODE != 0) ? ((32'(ptr) + k) % CHANNELS) : k;
            if (!found && cand[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_out <= '0;
            grant    <= '0;
            count    <= '0;
            ptr      <= '0;
        end else begin
            state <= state_next;
            if (found) begin
                addr_out <= addr_in[win*WIDTH +: WIDTH];
                grant    <= {{(CHANNELS-1){1'b0}}, 1'b1} << win;
                count    <= CW'(ACC_CYCLES - 1);
                if (RR_MODE != 0)
                    ptr <= (win == PW'(CHANNELS - 1)) ? '0 : win + 1'b1;
            end else if (last) begin
                grant <= '0;
            end else if (state == ACCESS) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (found)
                state_next = ACCESS;
        end else begin
            if (last && !found)
                state_next = IDLE;
        end
    end

    always_comb begin
        addr_valid = (state == ACCESS);
        busy       = (state == ACCESS);
        done       = last ? grant : '0;
    end

endmodule
